// File: rtl/regfile_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared definitions for the register-file write-back arbiter.
//   ADDR_WIDTH     : architectural register index width (x0..x31)
//   MAX_DATA_WIDTH : widest data path the request struct can carry
//   wr_req_t       : one write-back request {valid, addr, data}
//   STALL_MAX      : saturation value of the stall counter
//   rr_dist()      : circular distance of a requester from the scan start
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

   localparam int ADDR_WIDTH     = 5;
   localparam int MAX_DATA_WIDTH = 64;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   typedef struct packed {
      logic                      valid;
      logic [ADDR_WIDTH-1:0]     addr;
      logic [MAX_DATA_WIDTH-1:0] data;
   } wr_req_t;

   // Position of requester idx in a scan that starts at ptr; smaller means
   // the requester is visited earlier in this cycle.
   function automatic int unsigned rr_dist(int unsigned idx, int unsigned ptr,
                                           int unsigned n);
      return (idx + n - ptr) % n;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Request and register-file write bus of the write-back arbiter.
//   req_valid_i / req_ready_o : per-requester handshake. A write transfers in
//                               the cycle where valid and ready are both high;
//                               ready is a combinational grant, valid must not
//                               wait for ready.
//   req_addr_i / req_data_i   : destination register and data, only looked at
//                               while the matching valid is high.
//   we_o / waddr_o / wdata_o  : registered register-file write ports.
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface regfile_wr_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int NR_REQ     = 4,
   parameter int NR_WPORTS  = 2,
   parameter int DATA_WIDTH = 64
);

   logic [NR_REQ-1:0]                     req_valid_i;
   logic [NR_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i;
   logic [NR_REQ-1:0][DATA_WIDTH-1:0]     req_data_i;
   logic [NR_REQ-1:0]                     req_ready_o;

   logic [NR_WPORTS-1:0]                  we_o;
   logic [NR_WPORTS-1:0][ADDR_WIDTH-1:0]  waddr_o;
   logic [NR_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_o;

   modport master (
      output req_valid_i, req_addr_i, req_data_i,
      input  req_ready_o, we_o, waddr_o, wdata_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i,
      output req_ready_o, we_o, waddr_o, wdata_o
   );

endinterface

// File: rtl/regfile_wr_arbiter_rr_multi_pick.sv
// -----------------------------------------------------------------------------
// rr_multi_pick
// Circular multi-grant picker. Visits requesters starting at ptr_i and grants
// each asserted request until all NR_WPORTS ports are used. Ports are handed
// out in visit order.
//   req_i      : requests already filtered for conflicts/flush
//   ptr_i      : scan start
//   gnt_o      : granted requesters
//   port_idx_o : write port assigned to each granted requester
//   last_o     : last granted requester in scan order
//   any_o      : at least one grant this cycle
// -----------------------------------------------------------------------------
module rr_multi_pick #(
   parameter  int NR_REQ    = 4,
   parameter  int NR_WPORTS = 2,
   localparam int PTR_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
   localparam int PORT_W    = (NR_WPORTS > 1) ? $clog2(NR_WPORTS) : 1
) (
   input  logic [NR_REQ-1:0]             req_i,
   input  logic [PTR_W-1:0]              ptr_i,
   output logic [NR_REQ-1:0]             gnt_o,
   output logic [NR_REQ-1:0][PORT_W-1:0] port_idx_o,
   output logic [PTR_W-1:0]              last_o,
   output logic                          any_o
);

   always_comb begin
      int used;
      int idx;
      gnt_o      = '0;
      port_idx_o = '0;
      last_o     = '0;
      any_o      = 1'b0;
      used       = 0;
      idx        = 0;
      for (int k = 0; k < NR_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NR_REQ;
         if (req_i[idx] && (used < NR_WPORTS)) begin
            gnt_o[idx]      = 1'b1;
            port_idx_o[idx] = PORT_W'(used);
            last_o          = PTR_W'(idx);
            any_o           = 1'b1;
            used            = used + 1;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Arbitrates NR_REQ write-back requesters onto NR_WPORTS register-file write
// ports with a round-robin start pointer.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   flush_i     : suppresses all new grants for the cycle
//   bus         : request handshake and registered write ports (slave side)
//   stall_cnt_o : saturating count of cycles with an ungranted port request
//   rr_ptr_o    : current round-robin start pointer (debug visibility)
// Grants are combinational; the granted write appears on its port one cycle
// later. x0 writes (with ZERO_REG_ZERO) are acknowledged without using a port.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter  int NR_REQ        = 4,
   parameter  int NR_WPORTS     = 2,
   parameter  int DATA_WIDTH    = 64,
   parameter  int ZERO_REG_ZERO = 1,
   localparam int PTR_W         = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
   localparam int PORT_W        = (NR_WPORTS > 1) ? $clog2(NR_WPORTS) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   regfile_wr_arbiter_if.slave      bus,
   output logic [15:0]              stall_cnt_o,
   output logic [PTR_W-1:0]         rr_ptr_o
);

   wr_req_t                          req [NR_REQ];
   logic [NR_REQ-1:0]                zero_hit;
   logic [NR_REQ-1:0]                port_req;
   logic [NR_REQ-1:0]                conflict;
   logic [NR_REQ-1:0]                pick_req;
   logic [NR_REQ-1:0]                gnt;
   logic [NR_REQ-1:0][PORT_W-1:0]    port_idx;
   logic [PTR_W-1:0]                 last_gnt;
   logic                             any_gnt;
   logic                             stall;

   logic [NR_WPORTS-1:0]                 we_d,    we_q;
   logic [NR_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_d, waddr_q;
   logic [NR_WPORTS-1:0][DATA_WIDTH-1:0] wdata_d, wdata_q;
   logic [PTR_W-1:0]                     rr_ptr_d, rr_ptr_q;
   logic [15:0]                          stall_cnt_d, stall_cnt_q;

   // Request classification and same-address conflict masking.
   always_comb begin
      zero_hit = '0;
      port_req = '0;
      conflict = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         req[i].valid = bus.req_valid_i[i];
         req[i].addr  = bus.req_addr_i[i];
         req[i].data  = MAX_DATA_WIDTH'(bus.req_data_i[i]);
         zero_hit[i]  = req[i].valid && (ZERO_REG_ZERO != 0) && (req[i].addr == '0);
         port_req[i]  = req[i].valid && !zero_hit[i];
      end
      // A request waits if any port-consuming request earlier in this cycle's
      // scan targets the same register. Whether that earlier one is actually
      // granted does not matter: if it ran out of ports, so would this one.
      for (int i = 0; i < NR_REQ; i++) begin
         for (int j = 0; j < NR_REQ; j++) begin
            if ((i != j) && port_req[i] && port_req[j] &&
                (req[i].addr == req[j].addr) &&
                (rr_dist(j, int'(rr_ptr_q), NR_REQ) < rr_dist(i, int'(rr_ptr_q), NR_REQ)))
               conflict[i] = 1'b1;
         end
      end
      pick_req = port_req & ~conflict & {NR_REQ{!flush_i && !rst_i}};
   end

   rr_multi_pick #(
      .NR_REQ    (NR_REQ),
      .NR_WPORTS (NR_WPORTS)
   ) u_pick (
      .req_i      (pick_req),
      .ptr_i      (rr_ptr_q),
      .gnt_o      (gnt),
      .port_idx_o (port_idx),
      .last_o     (last_gnt),
      .any_o      (any_gnt)
   );

   // x0 writes complete immediately but still respect flush and reset.
   assign bus.req_ready_o = (rst_i || flush_i) ? '0 : (gnt | zero_hit);

   // Flush blocks grants on purpose, so it is not counted as a stall.
   assign stall = !flush_i && (|(port_req & ~gnt));

   always_comb begin
      we_d        = '0;
      waddr_d     = '0;
      wdata_d     = '0;
      rr_ptr_d    = rr_ptr_q;
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < NR_REQ; i++) begin
         if (gnt[i]) begin
            we_d[port_idx[i]]    = 1'b1;
            waddr_d[port_idx[i]] = req[i].addr;
            wdata_d[port_idx[i]] = req[i].data[DATA_WIDTH-1:0];
         end
      end
      if (any_gnt)
         rr_ptr_d = (last_gnt == PTR_W'(NR_REQ - 1)) ? '0 : last_gnt + 1'b1;
      if (stall && (stall_cnt_q != STALL_MAX))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q        <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         rr_ptr_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         rr_ptr_q    <= rr_ptr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.we_o    = we_q;
   assign bus.waddr_o = waddr_q;
   assign bus.wdata_o = wdata_q;
   assign stall_cnt_o = stall_cnt_q;
   assign rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter (4 requesters, 2 ports, 64-bit data,
// x0 writes discarded). One table row per cycle: inputs, the expected ready
// vector in that cycle, and the expected write ports / pointer / stall count
// after the following clock edge. Reset behaviour is exercised by hand.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
   import regfile_arb_pkg::*;

   localparam int NR_REQ    = 4;
   localparam int NR_WPORTS = 2;
   localparam int DW        = 64;
   localparam int NVEC      = 13;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] stall_cnt;
   logic [1:0]  rr_ptr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(
      .NR_REQ     (NR_REQ),
      .NR_WPORTS  (NR_WPORTS),
      .DATA_WIDTH (DW)
   ) bus ();

   regfile_wr_arbiter #(
      .NR_REQ        (NR_REQ),
      .NR_WPORTS     (NR_WPORTS),
      .DATA_WIDTH    (DW),
      .ZERO_REG_ZERO (1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .bus         (bus),
      .stall_cnt_o (stall_cnt),
      .rr_ptr_o    (rr_ptr)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_data(input int v, input int i);
      return {8'hDA, 24'(v), 24'h0, 8'(i)};
   endfunction

   typedef struct {
      logic             flush;
      logic [3:0]       valid;
      logic [3:0][4:0]  addr;
      logic [3:0]       exp_ready;
      logic [1:0]       exp_we;
      logic [1:0][4:0]  exp_waddr;
      logic [1:0][1:0]  exp_src;
      logic [1:0]       exp_ptr;
      logic [15:0]      exp_stall;
   } vec_t;

   function automatic vec_t mk_vec(
      input logic fl, input logic [3:0] v,
      input logic [4:0] a3, input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
      input logic [3:0] rdy, input logic [1:0] we,
      input logic [4:0] wa1, input logic [4:0] wa0,
      input logic [1:0] s1, input logic [1:0] s0,
      input logic [1:0] p, input logic [15:0] st);
      vec_t r;
      r.flush     = fl;
      r.valid     = v;
      r.addr      = {a3, a2, a1, a0};
      r.exp_ready = rdy;
      r.exp_we    = we;
      r.exp_waddr = {wa1, wa0};
      r.exp_src   = {s1, s0};
      r.exp_ptr   = p;
      r.exp_stall = st;
      return r;
   endfunction

   vec_t vt [NVEC];

   // ---------------- driver ----------------
   // Idle requesters get random addresses: they must not influence anything.
   task automatic drive(input logic fl, input logic [3:0] v, input logic [3:0][4:0] a, input int tag);
      flush = fl;
      for (int i = 0; i < NR_REQ; i++) begin
         bus.req_valid_i[i] = v[i];
         bus.req_addr_i[i]  = v[i] ? a[i] : 5'($urandom_range(0, 31));
         bus.req_data_i[i]  = mk_data(tag, i);
      end
   endtask

   // ---------------- test ----------------
   initial begin
      // flush valid  a3 a2 a1 a0  ready  we   wa1 wa0 s1 s0 ptr stall
      vt[0]  = mk_vec(0, 4'b0111,  0,  5,  4,  3, 4'b0011, 2'b11,  4,  3, 1, 0, 2, 1); // basic two-port grant
      vt[1]  = mk_vec(0, 4'b0000,  0,  0,  0,  0, 4'b0000, 2'b00,  0,  0, 0, 0, 2, 1); // idle
      vt[2]  = mk_vec(0, 4'b0011,  0,  0,  7,  7, 4'b0001, 2'b01,  0,  7, 0, 0, 1, 2); // same-address conflict
      vt[3]  = mk_vec(0, 4'b0010,  0,  0,  7,  0, 4'b0010, 2'b01,  0,  7, 0, 1, 2, 2); // loser goes next
      vt[4]  = mk_vec(0, 4'b0111,  0,  0, 11, 10, 4'b0111, 2'b11, 11, 10, 1, 0, 2, 2); // x0 plus two ports
      vt[5]  = mk_vec(0, 4'b0100,  0,  0,  0,  0, 4'b0100, 2'b00,  0,  0, 0, 0, 2, 2); // x0 alone
      vt[6]  = mk_vec(0, 4'b1111, 23, 22, 21, 20, 4'b1100, 2'b11, 23, 22, 3, 2, 0, 3); // fairness rotation
      vt[7]  = mk_vec(0, 4'b1111, 23, 22, 21, 20, 4'b0011, 2'b11, 21, 20, 1, 0, 2, 4);
      vt[8]  = mk_vec(0, 4'b1111, 23, 22, 21, 20, 4'b1100, 2'b11, 23, 22, 3, 2, 0, 5);
      vt[9]  = mk_vec(0, 4'b1111, 23, 22, 21, 20, 4'b0011, 2'b11, 21, 20, 1, 0, 2, 6);
      vt[10] = mk_vec(0, 4'b1000,  9,  0,  0,  0, 4'b1000, 2'b01,  0,  9, 0, 3, 0, 6); // grant, pointer wraps
      vt[11] = mk_vec(1, 4'b0011,  0,  0, 13, 12, 4'b0000, 2'b00,  0,  0, 0, 0, 0, 6); // flush
      vt[12] = mk_vec(0, 4'b0011,  0,  0, 13, 12, 4'b0011, 2'b11, 13, 12, 1, 0, 2, 6); // after flush

      // Reset with requests pending: ready stays low, outputs clear.
      rst = 1'b1;
      drive(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 99);
      @(negedge clk);
      check("reset ready", 64'(bus.req_ready_o), 64'h0);
      @(posedge clk); #1;
      check("reset we",      64'(bus.we_o),      64'h0);
      check("reset waddr",   64'(bus.waddr_o),   64'h0);
      check("reset wdata0",  bus.wdata_o[0],     64'h0);
      check("reset wdata1",  bus.wdata_o[1],     64'h0);
      check("reset stall",   64'(stall_cnt),     64'h0);
      check("reset rr_ptr",  64'(rr_ptr),        64'h0);
      rst = 1'b0;

      for (int v = 0; v < NVEC; v++) begin
         drive(vt[v].flush, vt[v].valid, vt[v].addr, v);
         @(negedge clk);
         check($sformatf("v%0d ready", v), 64'(bus.req_ready_o), 64'(vt[v].exp_ready));
         @(posedge clk); #1;
         check($sformatf("v%0d we", v), 64'(bus.we_o), 64'(vt[v].exp_we));
         for (int p = 0; p < NR_WPORTS; p++) begin
            check($sformatf("v%0d waddr%0d", v, p), 64'(bus.waddr_o[p]), 64'(vt[v].exp_waddr[p]));
            check($sformatf("v%0d wdata%0d", v, p), bus.wdata_o[p],
                  vt[v].exp_we[p] ? mk_data(v, int'(vt[v].exp_src[p])) : 64'h0);
         end
         check($sformatf("v%0d rr_ptr", v), 64'(rr_ptr),    64'(vt[v].exp_ptr));
         check($sformatf("v%0d stall", v),  64'(stall_cnt), 64'(vt[v].exp_stall));
      end

      // Reset hits while the pointer and stall counter are non-zero and all
      // four requesters are waiting: the reset-cycle grant is discarded.
      rst = 1'b1;
      drive(1'b0, 4'b1111, {5'd27, 5'd26, 5'd25, 5'd24}, 20);
      @(negedge clk);
      check("rst2 ready", 64'(bus.req_ready_o), 64'h0);
      @(posedge clk); #1;
      check("rst2 we",     64'(bus.we_o),    64'h0);
      check("rst2 stall",  64'(stall_cnt),   64'h0);
      check("rst2 rr_ptr", 64'(rr_ptr),      64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post-rst ready", 64'(bus.req_ready_o), 64'h3);
      @(posedge clk); #1;
      check("post-rst we",     64'(bus.we_o),       64'h3);
      check("post-rst waddr0", 64'(bus.waddr_o[0]), 64'd24);
      check("post-rst waddr1", 64'(bus.waddr_o[1]), 64'd25);
      check("post-rst wdata0", bus.wdata_o[0],      mk_data(20, 0));
      check("post-rst wdata1", bus.wdata_o[1],      mk_data(20, 1));
      check("post-rst rr_ptr", 64'(rr_ptr),         64'd2);
      check("post-rst stall",  64'(stall_cnt),      64'd1);

      drive(1'b0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 21);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
